// File: rtl/sw_sync_debounce_if.sv
// Switch-bank bus: raw switch levels and read strobe in, debounced word and
// change indicators out.
interface sw_sync_debounce_if #(
  parameter int unsigned N_SW   = 8,
  parameter int unsigned DATA_W = 16
);

  logic [N_SW-1:0]   sw;
  logic              rd;
  logic [DATA_W-1:0] SWR;
  logic [N_SW-1:0]   rise;
  logic [N_SW-1:0]   fall;
  logic              chg_pulse;
  logic              chg_flag;

  // master drives the switches and acknowledges; slave is the debouncer
  modport master (
    output sw, rd,
    input  SWR, rise, fall, chg_pulse, chg_flag
  );

  modport slave (
    input  sw, rd,
    output SWR, rise, fall, chg_pulse, chg_flag
  );

endinterface

// File: rtl/sw_sync_debounce.sv
// Per-bit two-flop synchronizer and hold-time debouncer for a switch bank,
// with edge pulses and a sticky change flag cleared by a read strobe.
module sw_sync_debounce #(
  parameter int unsigned N_SW      = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sw_sync_debounce_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0]  s1;
  logic [N_SW-1:0]  s2;
  logic [N_SW-1:0]  stable_q;
  logic [N_SW-1:0]  stable_d;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];
  logic [N_SW-1:0]  rise_q;
  logic [N_SW-1:0]  rise_d;
  logic [N_SW-1:0]  fall_q;
  logic [N_SW-1:0]  fall_d;
  logic             pulse_q;
  logic             pulse_d;
  logic             flag_q;
  logic             flag_d;

  // Synchronizer: nothing downstream ever sees raw sw
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.sw;
      s2 <= s1;
    end
  end

  // Debounce and event generation; an update is the last cycle of a full-length mismatch
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      cnt_d[i] = '0;
      if (s2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2[i];
          rise_d[i]   = s2[i];
          fall_d[i]   = ~s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    pulse_d = |(rise_d | fall_d);
    // A new change outranks a simultaneous acknowledge
    if (pulse_d) begin
      flag_d = 1'b1;
    end else if (bus.rd) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pulse_q  <= 1'b0;
      flag_q   <= 1'b0;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pulse_q  <= pulse_d;
      flag_q   <= flag_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // All outputs come straight from flops; upper readback bits are zero-filled
  assign bus.SWR       = DATA_W'(stable_q);
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.chg_pulse = pulse_q;
  assign bus.chg_flag  = flag_q;

endmodule

// File: tb/tb_sw_sync_debounce.sv
// Scoreboard bench for sw_sync_debounce (N_SW=8, DATA_W=16, DB_CYCLES=4):
// a behavioural model queues expected outputs each edge, plus directed scenarios.
module tb_sw_sync_debounce;

  localparam int unsigned N_SW      = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DB_CYCLES = 4;

  typedef struct {
    logic [DATA_W-1:0] swr;
    logic [N_SW-1:0]   rise;
    logic [N_SW-1:0]   fall;
    logic              pulse;
    logic              flag;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  exp_t sb [$];

  // reference model state
  logic [N_SW-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  logic            m_pulse, m_flag;
  int              m_cnt [N_SW];

  sw_sync_debounce_if #(.N_SW(N_SW), .DATA_W(DATA_W)) bus ();

  sw_sync_debounce #(
    .N_SW      (N_SW),
    .DATA_W    (DATA_W),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model of one rising edge using the inputs as driven
  task automatic model_step();
    logic [N_SW-1:0] nr, nf;
    nr = '0;
    nf = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      m_rise = '0; m_fall = '0; m_pulse = 1'b0; m_flag = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < int'(N_SW); i++) begin
        if (m_s2[i] == m_stable[i]) begin
          m_cnt[i] = 0;
        end else if (m_cnt[i] == int'(DB_CYCLES) - 1) begin
          m_stable[i] = m_s2[i];
          m_cnt[i] = 0;
          if (m_s2[i]) nr[i] = 1'b1;
          else         nf[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.sw;
      m_rise  = nr;
      m_fall  = nf;
      m_pulse = (nr != 0) || (nf != 0);
      if (m_pulse)     m_flag = 1'b1;
      else if (bus.rd) m_flag = 1'b0;
    end
  endtask

  // One clock: model predicts, expectation is queued, then popped against the DUT
  task automatic tick();
    exp_t e;
    @(posedge clk);
    model_step();
    sb.push_back('{swr: DATA_W'(m_stable), rise: m_rise, fall: m_fall,
                   pulse: m_pulse, flag: m_flag});
    #1;
    e = sb.pop_front();
    chk("sb_swr",   32'(bus.SWR),       32'(e.swr));
    chk("sb_rise",  32'(bus.rise),      32'(e.rise));
    chk("sb_fall",  32'(bus.fall),      32'(e.fall));
    chk("sb_pulse", 32'(bus.chg_pulse), 32'(e.pulse));
    chk("sb_flag",  32'(bus.chg_flag),  32'(e.flag));
  endtask

  task automatic ack();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  initial begin
    int rc;
    int hold;
    clk    = 1'b0;
    n_chk  = 0;
    n_pass = 0;
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_rise = '0; m_fall = '0; m_pulse = 1'b0; m_flag = 1'b0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    // Reset with switches already high: they appear as rises after release
    rst    = 1'b1;
    bus.sw = 8'hA5;
    bus.rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_swr", 32'(bus.SWR), 32'h0000);
      chk("rst_flag", 32'(bus.chg_flag), 32'h0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rel_early_swr", 32'(bus.SWR), 32'h0000);
      chk("rel_early_pulse", 32'(bus.chg_pulse), 32'h0);
    end
    tick();
    chk("rel_swr", 32'(bus.SWR), 32'h00A5);
    chk("rel_rise", 32'(bus.rise), 32'hA5);
    chk("rel_pulse", 32'(bus.chg_pulse), 32'h1);
    chk("rel_flag", 32'(bus.chg_flag), 32'h1);
    tick();
    chk("rel_rise_drop", 32'(bus.rise), 32'h00);
    chk("rel_flag_sticky", 32'(bus.chg_flag), 32'h1);
    ack();
    chk("ack_clear", 32'(bus.chg_flag), 32'h0);

    // Bring to all-zero, then a 3-cycle glitch must be ignored
    bus.sw = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    ack();
    bus.sw = 8'h01;
    for (int i = 0; i < 3; i++) tick();
    bus.sw = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_swr", 32'(bus.SWR), 32'h0000);
      chk("glitch_pulse", 32'(bus.chg_pulse | (|bus.rise) | (|bus.fall)), 32'h0);
      chk("glitch_flag", 32'(bus.chg_flag), 32'h0);
    end

    // Bounce 1,0,1,0,1 on sw[3] then hold: one rise, five edges after the last sample
    rc = 0;
    for (int t = 0; t < 14; t++) begin
      bus.sw = (t < 5) ? ((t % 2 == 0) ? 8'h08 : 8'h00) : 8'h08;
      tick();
      rc += int'(bus.rise[3]);
      if (t == 8) chk("bounce_before", 32'(bus.SWR[3]), 32'h0);
      if (t == 9) chk("bounce_at", 32'(bus.SWR), 32'h0008);
    end
    chk("bounce_rise_cnt", 32'(rc), 32'd1);

    // Acknowledge coinciding with an update keeps the flag; the next one clears it
    bus.sw = 8'h88;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_ack_flag", 32'(bus.chg_flag), 32'h1);
    bus.sw = 8'h08;
    for (int i = 0; i < 5; i++) tick();
    bus.rd = 1'b1;
    tick();
    chk("coinc_fall", 32'(bus.fall), 32'h80);
    chk("coinc_flag", 32'(bus.chg_flag), 32'h1);
    tick();
    chk("late_ack_flag", 32'(bus.chg_flag), 32'h0);
    bus.rd = 1'b0;

    // Reset mid-debounce discards the partial count
    bus.sw = 8'h00;
    for (int i = 0; i < 8; i++) tick();
    ack();
    bus.sw = 8'hFF;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_swr", 32'(bus.SWR), 32'h0000);
      chk("mid_rst_pulse", 32'(bus.chg_pulse), 32'h0);
    end
    tick();
    chk("mid_rst_swr_upd", 32'(bus.SWR), 32'h00FF);
    chk("mid_rst_rise", 32'(bus.rise), 32'hFF);

    // Random switch activity with random holds, acks and rare resets
    for (int n = 0; n < 120; n++) begin
      bus.sw = 8'($urandom);
      hold   = int'($urandom_range(1, 8));
      for (int h = 0; h < hold; h++) begin
        bus.rd = ($urandom_range(0, 5) == 0);
        rst    = ($urandom_range(0, 150) == 0);
        tick();
      end
    end
    rst    = 1'b0;
    bus.rd = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
